// File: rtl/ysyx_23060221_ifu.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_23060221_ifu
//  Purpose  : Multi-cycle instruction fetch unit (WBU pc in, IDU inst out)
//  Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060221_ifu #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc,
    input  logic             WBU_valid,
    output logic             IFU_ready,
    output logic [31:0]      araddr,
    output logic             arvalid,
    input  logic             arready,
    input  logic [31:0]      rdata,
    input  logic [1:0]       rresp,
    input  logic             rvalid,
    output logic             rready,
    output logic [31:0]      inst,
    output logic [31:0]      inst_pc,
    output logic [1:0]       fault,
    output logic             IFU_valid,
    input  logic             IDU_ready,
    output logic [CNT_W-1:0] fetch_cnt
);

    localparam int                c_tmo_w    = $clog2(TIMEOUT);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT - 1);

    localparam logic [1:0] c_fault_none  = 2'd0;
    localparam logic [1:0] c_fault_align = 2'd1;
    localparam logic [1:0] c_fault_bus   = 2'd2;
    localparam logic [1:0] c_fault_tmo   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_tmo_w-1:0] r_tmo_cnt;

    // All handshake outputs are registered and change together with r_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_tmo_cnt <= '0;
            IFU_ready <= 1'b1;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            IFU_valid <= 1'b0;
            araddr    <= 32'd0;
            inst      <= 32'd0;
            inst_pc   <= 32'd0;
            fault     <= c_fault_none;
            fetch_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (WBU_valid && IFU_ready) begin
                        inst_pc   <= pc;
                        IFU_ready <= 1'b0;
                        if (pc[1:0] == 2'b00) begin
                            araddr  <= pc;
                            arvalid <= 1'b1;
                            r_state <= S_REQ;
                        end else begin
                            // Misaligned: report straight away, never touch memory.
                            fault     <= c_fault_align;
                            inst      <= 32'd0;
                            IFU_valid <= 1'b1;
                            r_state   <= S_HOLD;
                        end
                    end
                end

                S_REQ: begin
                    if (arvalid && arready) begin
                        arvalid   <= 1'b0;
                        rready    <= 1'b1;
                        r_tmo_cnt <= '0;
                        r_state   <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (rvalid) begin
                        rready    <= 1'b0;
                        IFU_valid <= 1'b1;
                        r_state   <= S_HOLD;
                        if (rresp == 2'b00) begin
                            inst  <= rdata;
                            fault <= c_fault_none;
                        end else begin
                            inst  <= 32'd0;
                            fault <= c_fault_bus;
                        end
                    end else if (r_tmo_cnt == c_tmo_last) begin
                        // Dropping rready here makes any late response harmless.
                        inst      <= 32'd0;
                        fault     <= c_fault_tmo;
                        rready    <= 1'b0;
                        IFU_valid <= 1'b1;
                        r_state   <= S_HOLD;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end

                S_HOLD: begin
                    if (IDU_ready) begin
                        IFU_valid <= 1'b0;
                        IFU_ready <= 1'b1;
                        fetch_cnt <= fetch_cnt + 1'b1;
                        r_state   <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060221_ifu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_23060221_ifu
//  Purpose  : Self-checking bench for ysyx_23060221_ifu (table + random)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060221_ifu;

    localparam int c_timeout = 8;
    localparam int c_cnt_w   = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [31:0]        pc;
    logic               WBU_valid;
    logic               IFU_ready;
    logic [31:0]        araddr;
    logic               arvalid;
    logic               arready;
    logic [31:0]        rdata;
    logic [1:0]         rresp;
    logic               rvalid;
    logic               rready;
    logic [31:0]        inst;
    logic [31:0]        inst_pc;
    logic [1:0]         fault;
    logic               IFU_valid;
    logic               IDU_ready;
    logic [c_cnt_w-1:0] fetch_cnt;

    always #5 clk = ~clk;

    ysyx_23060221_ifu #(
        .TIMEOUT (c_timeout),
        .CNT_W   (c_cnt_w)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pc        (pc),
        .WBU_valid (WBU_valid),
        .IFU_ready (IFU_ready),
        .araddr    (araddr),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata     (rdata),
        .rresp     (rresp),
        .rvalid    (rvalid),
        .rready    (rready),
        .inst      (inst),
        .inst_pc   (inst_pc),
        .fault     (fault),
        .IFU_valid (IFU_valid),
        .IDU_ready (IDU_ready),
        .fetch_cnt (fetch_cnt)
    );

    typedef struct {
        logic [31:0] pc;
        int          ar_dly;
        int          r_dly;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        int          idu_dly;
        logic [31:0] exp_inst;
        logic [1:0]  exp_fault;
    } vec_t;

    vec_t               tbl [8];
    int                 vectors     = 0;
    int                 miscompares = 0;
    logic [c_cnt_w-1:0] exp_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference outcome of one fetch: {fault, inst}
    function automatic logic [33:0] ref_fetch(input logic [31:0] p, input int r_dly,
                                              input logic [31:0] d, input logic [1:0] resp);
        if (p % 4 != 0)       return {2'd1, 32'd0};
        if (r_dly >= c_timeout) return {2'd3, 32'd0};
        if (resp != 2'd0)     return {2'd2, 32'd0};
        return {2'd0, d};
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, "_ifu_ready"}, 32'(IFU_ready), 32'd1);
        chk({tag, "_arvalid"},   32'(arvalid),   32'd0);
        chk({tag, "_rready"},    32'(rready),    32'd0);
        chk({tag, "_ifu_valid"}, 32'(IFU_valid), 32'd0);
        chk({tag, "_araddr"},    araddr,         32'd0);
        chk({tag, "_inst"},      inst,           32'd0);
        chk({tag, "_inst_pc"},   inst_pc,        32'd0);
        chk({tag, "_fault"},     32'(fault),     32'd0);
        chk({tag, "_fetch_cnt"}, 32'(fetch_cnt), 32'd0);
    endtask

    // Plays WBU, memory and IDU for one fetch and checks every cycle of it.
    task automatic do_fetch(input logic [31:0] p, input int ar_dly, input int r_dly,
                            input logic [31:0] d, input logic [1:0] resp, input int idu_dly,
                            input logic [31:0] e_inst, input logic [1:0] e_fault);
        chk("idle_ready", 32'(IFU_ready), 32'd1);
        pc        = p;
        WBU_valid = 1'b1;
        step();
        pc = $urandom;  // WBU keeps offering junk; it must not be consumed
        chk("busy_ready", 32'(IFU_ready), 32'd0);
        if (p[1:0] == 2'b00) begin
            rvalid = 1'b1;  // stray response during REQ must be ignored
            rdata  = $urandom;
            rresp  = 2'd0;
            for (int i = 0; i < ar_dly; i++) begin
                chk("req_arvalid", 32'(arvalid), 32'd1);
                chk("req_araddr",  araddr,       p);
                chk("req_rready",  32'(rready),  32'd0);
                step();
            end
            chk("req_arvalid", 32'(arvalid), 32'd1);
            chk("req_araddr",  araddr,       p);
            arready = 1'b1;
            step();
            arready = 1'b0;
            rvalid  = 1'b0;
            chk("wait_arvalid", 32'(arvalid), 32'd0);
            for (int i = 0; i < r_dly && i < c_timeout; i++) begin
                chk("wait_rready",    32'(rready),    32'd1);
                chk("wait_ifu_valid", 32'(IFU_valid), 32'd0);
                step();
            end
            if (r_dly < c_timeout) begin
                chk("wait_rready", 32'(rready), 32'd1);
                rvalid = 1'b1;
                rdata  = d;
                rresp  = resp;
                step();
                rvalid = 1'b0;
            end else begin
                rvalid = 1'b1;  // late response after timeout
                rdata  = $urandom;
                rresp  = 2'd0;
            end
        end else begin
            chk("misalign_arvalid", 32'(arvalid), 32'd0);
        end
        chk("hold_ifu_valid", 32'(IFU_valid), 32'd1);
        chk("hold_arvalid",   32'(arvalid),   32'd0);
        chk("hold_rready",    32'(rready),    32'd0);
        chk("hold_inst",      inst,           e_inst);
        chk("hold_fault",     32'(fault),     32'(e_fault));
        chk("hold_inst_pc",   inst_pc,        p);
        for (int i = 0; i < idu_dly; i++) begin
            step();
            chk("stall_ifu_valid", 32'(IFU_valid), 32'd1);
            chk("stall_rready",    32'(rready),    32'd0);
            chk("stall_inst",      inst,           e_inst);
            chk("stall_fault",     32'(fault),     32'(e_fault));
            chk("stall_inst_pc",   inst_pc,        p);
        end
        IDU_ready = 1'b1;
        step();
        IDU_ready = 1'b0;
        WBU_valid = 1'b0;
        rvalid    = 1'b0;
        exp_cnt   = exp_cnt + 1'b1;
        chk("done_fetch_cnt", 32'(fetch_cnt), 32'(exp_cnt));
        chk("done_ifu_valid", 32'(IFU_valid), 32'd0);
        chk("done_ifu_ready", 32'(IFU_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] rp;
        logic [31:0] rd;
        logic [1:0]  rr;
        int          rdl;
        logic [33:0] exp;

        tbl[0] = '{32'h2000_0000, 0,   0, 32'h0010_0093, 2'd0, 0, 32'h0010_0093, 2'd0};
        tbl[1] = '{32'h2000_0010, 4,   5, 32'hDEAD_BEEF, 2'd0, 3, 32'hDEAD_BEEF, 2'd0};
        tbl[2] = '{32'h2000_0002, 0,   0, 32'h1234_5678, 2'd0, 1, 32'h0000_0000, 2'd1};
        tbl[3] = '{32'h2000_0008, 1,   2, 32'hFFFF_FFFF, 2'd2, 0, 32'h0000_0000, 2'd2};
        tbl[4] = '{32'h2000_000C, 0, 100, 32'hA5A5_A5A5, 2'd0, 2, 32'h0000_0000, 2'd3};
        tbl[5] = '{32'h2000_0014, 0,   7, 32'h0BAD_F00D, 2'd0, 0, 32'h0BAD_F00D, 2'd0};
        tbl[6] = '{32'h2000_0003, 0,   0, 32'h0000_0000, 2'd0, 0, 32'h0000_0000, 2'd1};
        tbl[7] = '{32'h2000_0018, 2,   6, 32'h1111_1111, 2'd1, 1, 32'h0000_0000, 2'd2};

        rst       = 1'b1;
        pc        = 32'd0;
        WBU_valid = 1'b0;
        arready   = 1'b0;
        rdata     = 32'd0;
        rresp     = 2'd0;
        rvalid    = 1'b0;
        IDU_ready = 1'b0;
        exp_cnt   = '0;
        step();
        step();
        check_reset_values("por");
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_fetch(tbl[i].pc, tbl[i].ar_dly, tbl[i].r_dly, tbl[i].rdata, tbl[i].rresp,
                     tbl[i].idu_dly, tbl[i].exp_inst, tbl[i].exp_fault);
        end

        for (int i = 0; i < 60; i++) begin
            rp = $urandom;
            if ($urandom_range(0, 3) != 0) rp[1:0] = 2'b00;
            rd  = $urandom;
            rr  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            rdl = ($urandom_range(0, 4) == 0) ? $urandom_range(6, 12) : $urandom_range(0, 3);
            exp = ref_fetch(rp, rdl, rd, rr);
            do_fetch(rp, $urandom_range(0, 3), rdl, rd, rr, $urandom_range(0, 2),
                     exp[31:0], exp[33:32]);
        end

        // Reset while waiting for read data; the response that follows is ignored.
        pc        = 32'h2000_0020;
        WBU_valid = 1'b1;
        step();
        WBU_valid = 1'b0;
        arready   = 1'b1;
        step();
        arready = 1'b0;
        chk("midrst_wait_rready", 32'(rready), 32'd1);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_values("midrst");
        exp_cnt = '0;
        rvalid  = 1'b1;
        rdata   = 32'hCAFE_BABE;
        step();
        rvalid = 1'b0;
        chk("midrst_late_ifu_valid", 32'(IFU_valid), 32'd0);
        chk("midrst_late_inst",      inst,           32'd0);

        // Five fetches after reset: counter reads 1,2,3,0,1.
        do_fetch(32'h2000_0004, 0, 1, 32'h0000_0013, 2'd0, 0, 32'h0000_0013, 2'd0);
        for (int i = 0; i < 4; i++) begin
            rp = 32'h2000_0100 + 32'(i * 4);
            do_fetch(rp, 0, 0, rp ^ 32'h5555_0000, 2'd0, 0, rp ^ 32'h5555_0000, 2'd0);
        end
        chk("wrap_final_cnt", 32'(fetch_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ysyx_23060221_ifu.md
Name: ysyx_23060221_ifu

Overview:
Instruction fetch unit of the multi-cycle core; sits directly downstream of the write-back stage, which delivers the next PC.
- Accepts the PC over a valid/ready handshake from WBU.
- Fetches one 32-bit instruction over a simple read-address/read-data memory channel.
- Presents the instruction to IDU over a valid/ready handshake.
- Detects misaligned PCs, bus errors and response timeouts, and flags them to IDU as access faults.

Parameters:
TIMEOUT, 256, max cycles in WAIT before a fetch is declared faulted (≥2)
CNT_W, 32, width of retired-fetch counter

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous active-high reset
pc  in  32  next PC from WBU
WBU_valid  in  1  WBU holds a valid pc
IFU_ready  out  1  IFU can accept a pc
araddr  out  32  memory read address
arvalid  out  1  read request valid
arready  in  1  memory accepts request
rdata  in  32  read data
rresp  in  2  read response; 0 = OK, nonzero = error
rvalid  in  1  read data valid
rready  out  1  IFU accepts read data
inst  out  32  fetched instruction to IDU
inst_pc  out  32  PC of inst
fault  out  2  0 none, 1 misaligned, 2 bus error, 3 timeout
IFU_valid  out  1  inst/inst_pc/fault valid
IDU_ready  in  1  IDU accepts
fetch_cnt  out  CNT_W  completed IDU handshakes

Behaviour:
- Reset values:
  - State IDLE; IFU_ready=1.
  - arvalid=0, rready=0, IFU_valid=0.
  - araddr=0, inst=0, inst_pc=0, fault=0, fetch_cnt=0.
  - Timeout counter 0.
- Reset takes effect mid-operation in any state. An in-flight memory response arriving after reset is ignored because rready=0.
- States: IDLE, REQ, WAIT, HOLD. Registered outputs are set as follows.
  - IFU_ready=1 only in IDLE.
  - arvalid=1 only in REQ.
  - rready=1 only in WAIT.
  - IFU_valid=1 only in HOLD.
- IDLE, edge with WBU_valid & IFU_ready:
  - Always: latch inst_pc<=pc; IFU_ready<=0.
  - If pc[1:0]==0: araddr<=pc, arvalid<=1, go REQ.
  - Else: fault<=1, inst<=0, IFU_valid<=1, go HOLD. No memory request is issued.
- REQ, edge with arvalid & arready: arvalid<=0, rready<=1, clear timeout counter, go WAIT. arvalid, once asserted, stays high with araddr stable until accepted. rvalid in REQ is ignored.
- WAIT, edge with rvalid:
  - rready<=0, IFU_valid<=1, go HOLD.
  - If rresp==0: inst<=rdata, fault<=0.
  - Else: inst<=0, fault<=2.
- WAIT, no rvalid:
  - Timeout counter increments each cycle.
  - When the counter reaches TIMEOUT-1 without rvalid: inst<=0, fault<=3, rready<=0, IFU_valid<=1, go HOLD.
  - A late response is then dropped, since rready=0.
- HOLD:
  - inst, inst_pc and fault stay stable while IFU_valid=1 and IDU_ready=0.
  - On edge with IDU_ready: IFU_valid<=0, IFU_ready<=1, fetch_cnt<=fetch_cnt+1 (wraps modulo 2^CNT_W), go IDLE.
  - Faulted fetches are counted too.
- Minimum latency from the PC handshake to IFU_valid is 3 edges: accept → REQ, arready → WAIT, rvalid → HOLD.
- Only one fetch is outstanding; a new PC is never accepted before the IDU handshake. WBU_valid in any state other than IDLE is not consumed.
- After reset, WBU asserts WBU_valid with pc=0x20000000. IFU fetches it with no special-casing.

Test Plan:
- Zero-wait fetch: rst, then WBU_valid with pc=0x20000000; arready=1, rvalid=1 next cycle, rdata=0x00100093, rresp=0, IDU_ready=1 → araddr=0x20000000; IFU_valid on 3rd edge after accept with inst=0x00100093, inst_pc=0x20000000, fault=0; fetch_cnt=1; IFU_ready=1 again.
- Backpressure: arready low 4 cycles, rvalid delayed 5 cycles, IDU_ready low 3 cycles → arvalid/araddr stable until accept; rready high throughout WAIT; inst stable while IFU_valid & !IDU_ready; exactly one fetch counted.
- Misaligned: pc=0x20000002 → arvalid never asserts; next edge IFU_valid=1, fault=1, inst=0, inst_pc=0x20000002.
- Bus error then timeout:
  - rresp=2 with rdata=0xFFFFFFFF → fault=2, inst=0.
  - With TIMEOUT=8, never assert rvalid → fault=3 after 8 WAIT cycles; a later rvalid is not consumed (rready=0).
- Reset mid-fetch: assert rst during WAIT → next edge all outputs at reset values, state IDLE; a subsequent fetch of 0x20000004 completes normally with fetch_cnt=1.
- Counter wrap: CNT_W=2, 5 back-to-back fetches → fetch_cnt sequence 1,2,3,0,1.
